// File: rtl/attn_core_seq.sv
// attn_core_seq: drives the attention core instruction word; forwards host
// instructions while idle and runs kernel-load / Q-exec / drain / normalize passes.
module attn_core_seq #(
    parameter int col       = 8,
    parameter int kwait     = 4,
    parameter int drain_max = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  n_q_m1,
    input  logic [18:0] host_inst,
    output logic        host_rej,
    input  logic        ofifo_valid,
    output logic [18:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam logic [2:0] s_idle  = 3'd0;
    localparam logic [2:0] s_kload = 3'd1;
    localparam logic [2:0] s_kwait = 3'd2;
    localparam logic [2:0] s_qexec = 3'd3;
    localparam logic [2:0] s_drain = 3'd4;
    localparam logic [2:0] s_norm  = 3'd5;
    localparam logic [2:0] s_done  = 3'd6;
    localparam int cw = $clog2(col + kwait + drain_max + 18);

    logic [2:0]    state, state_n;
    logic [cw-1:0] cnt, cnt_n;
    logic [3:0]    nq, row, row_n;
    logic [1:0]    sub, sub_n;
    logic [18:0]   inst_n;
    logic          err_n, active, accept;

    assign active = state != s_idle && state != s_done;
    assign accept = state == s_idle && start;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        row_n   = row;
        sub_n   = sub;
        inst_n  = '0;
        err_n   = err;
        case (state)
            s_idle: begin
                inst_n = start ? '0 : host_inst;
                cnt_n  = '0;
                if (start) begin
                    state_n = s_kload;
                    err_n   = 1'b0;
                end
            end
            s_kload:
                if (cnt < cw'(col)) inst_n = {3'b0, cnt[3:0], 4'b0, 8'h48};
                else begin
                    // trailing cycle keeps kernel-load asserted for the SRAM read latency
                    inst_n  = 19'h00040;
                    state_n = s_kwait;
                    cnt_n   = '0;
                end
            s_kwait:
                if (cnt == cw'(kwait - 1)) begin
                    state_n = s_qexec;
                    cnt_n   = '0;
                end
            s_qexec:
                if (cnt <= cw'(nq)) inst_n = {3'b0, cnt[3:0], 4'b0, 8'ha0};
                else begin
                    inst_n  = 19'h00080;
                    state_n = s_drain;
                    cnt_n   = '0;
                end
            s_drain:
                if (ofifo_valid) begin
                    state_n = s_norm;
                    row_n   = '0;
                    sub_n   = '0;
                end else if (cnt == cw'(drain_max - 1)) begin
                    err_n   = 1'b1;
                    state_n = s_done;
                end
            s_norm:
                case (sub)
                    2'd0: if (ofifo_valid) begin
                        inst_n = 19'h10000;
                        sub_n  = 2'd1;
                    end
                    2'd1: begin
                        inst_n = 19'h20000;
                        sub_n  = 2'd2;
                    end
                    2'd2: begin
                        inst_n = 19'h40000;
                        sub_n  = 2'd3;
                    end
                    default: begin
                        inst_n = {7'b0, row, 8'h01};
                        sub_n  = 2'd0;
                        row_n  = row + 1'b1;
                        if (row == nq) state_n = s_done;
                    end
                endcase
            default: state_n = s_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= s_idle;
            cnt      <= '0;
            nq       <= '0;
            row      <= '0;
            sub      <= '0;
            inst     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            host_rej <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            row      <= row_n;
            sub      <= sub_n;
            inst     <= inst_n;
            err      <= err_n;
            busy     <= active || accept;
            done     <= state == s_done;
            host_rej <= active && |host_inst;
            if (accept) nq <= n_q_m1;
        end
    end
endmodule
